// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module  : ccff_bitstream_loader
// Purpose : streams config words LSB-first into a ccff chain, returns old bits
// Revision: 1.0
// ============================================================================
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int DATA_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              busy,
  output logic              done
);
  localparam int BC_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(CHAIN_LEN - 1);
  localparam logic [BC_W-1:0] BIT_END   = BC_W'(CHAIN_LEN);
  localparam logic [WB_W-1:0] WORD_LAST = WB_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] sreg, rb_sreg, rb_word;
  logic [BC_W-1:0]   bit_cnt;
  logic [WB_W-1:0]   word_bit, rb_cnt;
  logic              shift_en, take_word, clear_cnt, rb_emit;
  logic              word_end, last_bit;

  assign word_end = (word_bit == WORD_LAST);
  assign last_bit = (bit_cnt == BIT_LAST);
  assign busy     = (state == WAIT) || (state == LOAD);
  assign done     = (state == DONE);

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    shift_en   = 1'b0;
    take_word  = 1'b0;
    clear_cnt  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_next = WAIT;
          clear_cnt  = 1'b1;
        end
      end
      WAIT: begin
        s_ready = !abort;
        if (abort) begin
          state_next = IDLE;
        end else if (s_valid) begin
          take_word  = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (bit_cnt == BIT_END) begin
          // the final enable is on the chain this cycle; finish after it
          state_next = DONE;
        end else begin
          shift_en = 1'b1;
          if (word_end && !last_bit) begin
            s_ready = 1'b1;
            if (s_valid) take_word  = 1'b1;
            else         state_next = WAIT;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rb_word         = rb_sreg;
    rb_word[rb_cnt] = ccff_tail;
  end

  assign rb_emit = (rb_cnt == WORD_LAST) || ((bit_cnt == BIT_END) && !abort);

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      sreg         <= '0;
      bit_cnt      <= '0;
      word_bit     <= '0;
      rb_sreg      <= '0;
      rb_cnt       <= '0;
      ccff_head    <= 1'b0;
      chain_clk_en <= 1'b0;
      m_data       <= '0;
      m_valid      <= 1'b0;
    end else begin
      m_valid      <= 1'b0;
      chain_clk_en <= shift_en;
      if (shift_en) begin
        ccff_head <= sreg[0];
        bit_cnt   <= bit_cnt + 1'b1;
        sreg      <= sreg >> 1;
        word_bit  <= word_end ? '0 : word_bit + 1'b1;
      end
      if (take_word) begin
        sreg     <= s_data;
        word_bit <= '0;
      end
      // tail bit leaves the chain on the same edge the enable is consumed
      if (chain_clk_en) begin
        if (rb_emit) begin
          m_data  <= rb_word;
          m_valid <= 1'b1;
          rb_sreg <= '0;
          rb_cnt  <= '0;
        end else begin
          rb_sreg <= rb_word;
          rb_cnt  <= rb_cnt + 1'b1;
        end
      end
      if (clear_cnt) begin
        bit_cnt  <= '0;
        word_bit <= '0;
        rb_sreg  <= '0;
        rb_cnt   <= '0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_ccff_bitstream_loader
// Purpose : directed + randomized checks of ccff_bitstream_loader with a chain model
// Revision: 1.0
// ============================================================================
module tb_ccff_bitstream_loader;
  localparam int CL = 20;
  localparam int DW = 8;
  localparam int NW = (CL + DW - 1) / DW;

  logic          prog_clk = 1'b0;
  logic          pReset, start, abort, s_valid, s_ready;
  logic [DW-1:0] s_data, m_data;
  logic          ccff_head, chain_clk_en, ccff_tail, m_valid, busy, done;

  ccff_bitstream_loader #(.CHAIN_LEN(CL), .DATA_W(DW)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ccff_head(ccff_head), .chain_clk_en(chain_clk_en), .ccff_tail(ccff_tail),
    .m_data(m_data), .m_valid(m_valid), .busy(busy), .done(done)
  );

  always #5 prog_clk = ~prog_clk;

  // downstream chain: head enters at the top, tail leaves from bit 0
  logic [CL-1:0] chain = '0;
  logic [CL-1:0] preload_val = '0;
  logic          preload_req = 1'b0;
  always @(posedge prog_clk) begin
    if (preload_req)       chain <= preload_val;
    else if (chain_clk_en) chain <= {ccff_head, chain[CL-1:1]};
  end
  assign ccff_tail = chain[0];

  bit          head_q[$];
  int          en_cyc_q[$];
  logic [DW-1:0] mv_q[$];
  int          mv_cyc_q[$];
  int          cyc = 0, hs_cnt = 0, hold_viol = 0, done_rise_cyc = -1;
  logic        done_prev = 1'b0, rst_prev = 1'b1, head_prev = 1'b0;

  always @(negedge prog_clk) begin
    cyc <= cyc + 1;
    if (chain_clk_en) begin
      head_q.push_back(ccff_head);
      en_cyc_q.push_back(cyc);
    end
    if (m_valid) begin
      mv_q.push_back(m_data);
      mv_cyc_q.push_back(cyc);
    end
    if (done && !done_prev) done_rise_cyc <= cyc;
    if (s_valid && s_ready) hs_cnt <= hs_cnt + 1;
    if (!pReset && !rst_prev && !chain_clk_en && (ccff_head !== head_prev))
      hold_viol <= hold_viol + 1;
    done_prev <= done;
    rst_prev  <= pReset;
    head_prev <= ccff_head;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic feed_word(input logic [DW-1:0] w);
    bit ok;
    ok = 1'b0;
    s_data  = w;
    s_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      #1;
      if (s_ready) ok = 1'b1;
      step();
    end
    chk("word_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // one full load; expectations come from the bit-stream / old-chain rules
  task automatic run_load(input logic [DW-1:0] w0, w1, w2, input int gap_idx, input int gap_len,
                          input bit do_pre, input logic [CL-1:0] pre, input bit extra_start);
    logic [DW-1:0]    w[NW];
    logic [NW*DW-1:0] stream;
    logic [CL-1:0]    old, hv;
    logic [DW-1:0]    ev, ov;
    int               h0, m0, hs0, span;
    w[0] = w0; w[1] = w1; w[2] = w2;
    stream = {w2, w1, w0};
    if (do_pre) begin
      preload_val = pre;
      preload_req = 1'b1;
      step();
      preload_req = 1'b0;
    end
    old = chain;
    h0  = head_q.size();
    m0  = mv_q.size();
    hs0 = hs_cnt;
    start_pulse();
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_done_clr", {31'd0, done}, 32'd0);
    if (extra_start) begin
      start_pulse();
      chk("restart_busy", {31'd0, busy}, 32'd1);
      chk("restart_ready", {31'd0, s_ready}, 32'd1);
      chk("restart_no_en", head_q.size() - h0, 32'd0);
    end
    for (int i = 0; i < NW; i++) begin
      if (i == gap_idx && gap_len > 0) begin
        s_valid = 1'b0;
        for (int t = 0; t < 200 && !s_ready; t++) step();
        repeat (gap_len) step();
      end
      feed_word(w[i]);
    end
    s_data = DW'($urandom);
    for (int t = 0; t < 200 && !done; t++) step();
    s_valid = 1'b0;
    chk("done_set", {31'd0, done}, 32'd1);
    step();
    step();
    chk("en_count", head_q.size() - h0, CL);
    chk("handshakes", hs_cnt - hs0, NW);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("ready_after", {31'd0, s_ready}, 32'd0);
    hv = '0;
    for (int k = 0; k < CL; k++) if (h0 + k < head_q.size()) hv[k] = head_q[h0 + k];
    chk("head_seq", 32'(hv), 32'(stream[CL-1:0]));
    chk("chain_final", 32'(chain), 32'(stream[CL-1:0]));
    chk("rb_count", mv_q.size() - m0, NW);
    for (int j = 0; j < NW; j++) begin
      ev = '0;
      for (int b = 0; b < DW; b++) if (j * DW + b < CL) ev[b] = old[j * DW + b];
      ov = (m0 + j < mv_q.size()) ? mv_q[m0 + j] : ~ev;
      chk("rb_word", 32'(ov), 32'(ev));
    end
    if (mv_cyc_q.size() > 0)
      chk("rb_last_at_done", mv_cyc_q[mv_cyc_q.size() - 1], done_rise_cyc);
    span = (en_cyc_q.size() >= h0 + CL) ? en_cyc_q[h0 + CL - 1] - en_cyc_q[h0] + 1 : -1;
    chk("en_span", span, CL + ((gap_idx > 0) ? gap_len : 0));
  endtask

  int h_at, m_at, m0, h0, hs0;

  initial begin
    pReset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) step();
    pReset = 1'b0;
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_en", {31'd0, chain_clk_en}, 32'd0);
    chk("rst_head", {31'd0, ccff_head}, 32'd0);
    chk("rst_mvalid", {31'd0, m_valid}, 32'd0);

    // gapless streaming, then with the chain holding all ones
    run_load(8'hA5, 8'h3C, 8'h0F, 0, 0, 1'b0, '0, 1'b0);
    run_load(8'hA5, 8'h3C, 8'h0F, 0, 0, 1'b1, 20'hFFFFF, 1'b0);
    // five-cycle stall between the first and second word
    run_load(8'hA5, 8'h3C, 8'h0F, 1, 5, 1'b1, 20'($urandom), 1'b0);

    // abort part-way through the second word
    preload_val = 20'($urandom); preload_req = 1'b1; step(); preload_req = 1'b0;
    h0 = head_q.size(); m0 = mv_q.size();
    start_pulse();
    feed_word(DW'($urandom));
    feed_word(DW'($urandom));
    s_valid = 1'b0;
    for (int t = 0; t < 200 && (head_q.size() - h0) < 11; t++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, s_ready}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_en", {31'd0, chain_clk_en}, 32'd0);
    h_at = head_q.size(); m_at = mv_q.size();
    repeat (6) step();
    chk("abort_no_flush", mv_q.size() - m_at, 32'd0);
    chk("abort_rb_words", m_at - m0, 32'd1);
    chk("abort_no_en", head_q.size() - h_at, 32'd0);

    // s_valid in IDLE is ignored
    hs0 = hs_cnt; h0 = head_q.size();
    s_valid = 1'b1; s_data = DW'($urandom);
    repeat (4) begin
      step();
      chk("idle_ready", {31'd0, s_ready}, 32'd0);
    end
    s_valid = 1'b0;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_no_hs", hs_cnt - hs0, 32'd0);
    chk("idle_no_en", head_q.size() - h0, 32'd0);

    // abort beats a same-cycle handshake in WAIT
    start_pulse();
    s_valid = 1'b1; abort = 1'b1; s_data = DW'($urandom);
    #1;
    chk("abort_vs_hs_ready", {31'd0, s_ready}, 32'd0);
    step();
    abort = 1'b0; s_valid = 1'b0;
    chk("abort_vs_hs_busy", {31'd0, busy}, 32'd0);
    repeat (3) step();
    chk("abort_vs_hs_no_en", head_q.size() - h0, 32'd0);

    run_load(DW'($urandom), DW'($urandom), DW'($urandom), 0, 0, 1'b0, '0, 1'b0);

    // asynchronous reset mid-load
    start_pulse();
    h0 = head_q.size();
    feed_word(DW'($urandom));
    s_valid = 1'b0;
    for (int t = 0; t < 200 && (head_q.size() - h0) < 7; t++) step();
    pReset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_en", {31'd0, chain_clk_en}, 32'd0);
    chk("arst_head", {31'd0, ccff_head}, 32'd0);
    chk("arst_ready", {31'd0, s_ready}, 32'd0);
    chk("arst_mdata", 32'(m_data), 32'd0);
    chk("arst_mvalid", {31'd0, m_valid}, 32'd0);
    step();
    step();
    pReset = 1'b0;
    step();
    run_load(DW'($urandom), DW'($urandom), DW'($urandom), 0, 0, 1'b1, 20'($urandom), 1'b0);

    // start while busy, then randomized loads with stalls
    run_load(DW'($urandom), DW'($urandom), DW'($urandom), 0, 0, 1'b1, 20'($urandom), 1'b1);
    for (int r = 0; r < 4; r++)
      run_load(DW'($urandom), DW'($urandom), DW'($urandom), int'($urandom_range(1, 2)),
               int'($urandom_range(0, 6)), 1'b1, 20'($urandom), 1'b0);

    chk("head_hold", hold_viol, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
